// File: rtl/btn_conditioner_pkg.sv
// Shared types and helpers for the button conditioner: debounce FSM states
// and counter sizing.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } db_state_t;

  // Bits needed to hold values 0..max_val (never less than one).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_db_chan.sv
// One button channel: two-flop synchronizer, debounce FSM, auto-repeat
// counter and registered level/tick outputs.
module btn_db_chan
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = 500_000,
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic tick
);

  localparam int DB_W    = cnt_w(DB_CYCLES - 1);
  localparam int REP_MAX = ((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD) - 1;
  localparam int REP_W   = cnt_w(REP_MAX);

  localparam logic [DB_W-1:0]  DB_LOAD         = DB_W'(DB_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_DELAY_LOAD  = REP_W'((REP_DELAY > 0) ? REP_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] REP_PERIOD_LOAD = REP_W'(REP_PERIOD - 1);

  logic             meta_reg, sync_reg;
  db_state_t        state_reg, state_next;
  logic [DB_W-1:0]  db_cnt_reg, db_cnt_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             level_reg, level_next;
  logic             tick_reg, tick_next;
  logic             press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg    <= 1'b0;
      sync_reg    <= 1'b0;
      state_reg   <= ST_ZERO;
      db_cnt_reg  <= '0;
      rep_cnt_reg <= '0;
      level_reg   <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      meta_reg    <= raw;
      sync_reg    <= meta_reg;
      state_reg   <= state_next;
      db_cnt_reg  <= db_cnt_next;
      rep_cnt_reg <= rep_cnt_next;
      level_reg   <= level_next;
      tick_reg    <= tick_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    db_cnt_next  = db_cnt_reg;
    rep_cnt_next = rep_cnt_reg;
    tick_next    = 1'b0;
    press        = 1'b0;

    unique case (state_reg)
      ST_ZERO: begin
        if (sync_reg) begin
          state_next  = ST_WAIT1;
          db_cnt_next = DB_LOAD;
        end
      end
      ST_WAIT1: begin
        if (!sync_reg) begin
          state_next = ST_ZERO;
        end else if (db_cnt_reg != '0) begin
          db_cnt_next = db_cnt_reg - DB_W'(1);
        end else begin
          state_next = ST_ONE;
          press      = 1'b1;
        end
      end
      ST_ONE: begin
        if (!sync_reg) begin
          state_next  = ST_WAIT0;
          db_cnt_next = DB_LOAD;
        end
      end
      ST_WAIT0: begin
        if (sync_reg) begin
          state_next = ST_ONE;
        end else if (db_cnt_reg == '0) begin
          state_next = ST_ZERO;
        end else begin
          db_cnt_next = db_cnt_reg - DB_W'(1);
        end
      end
    endcase

    // A bounce back from WAIT0 to ONE keeps the repeat cadence running;
    // only a real press reloads the initial delay.
    if (press) begin
      tick_next    = 1'b1;
      rep_cnt_next = REP_DELAY_LOAD;
    end else if (state_next == ST_ZERO) begin
      rep_cnt_next = '0;
    end else if ((REP_DELAY != 0) &&
                 ((state_reg == ST_ONE) || (state_reg == ST_WAIT0))) begin
      if (rep_cnt_reg == '0) begin
        tick_next    = 1'b1;
        rep_cnt_next = REP_PERIOD_LOAD;
      end else begin
        rep_cnt_next = rep_cnt_reg - REP_W'(1);
      end
    end

    level_next = (state_next == ST_ONE) || (state_next == ST_WAIT0);
  end

  assign level = level_reg;
  assign tick  = tick_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Input conditioning for the text-screen generator: debounced buttons with
// press/repeat ticks, plus a synchronized switch bus.
module btn_conditioner #(
  parameter int N_BTN      = 3,
  parameter int N_SW       = 7,
  parameter int DB_CYCLES  = 500_000,
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_tick,
  output logic [N_SW-1:0]  sw_sync
);

  logic [N_SW-1:0] sw_meta_reg, sw_sync_reg;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_db_chan #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
      ) u_chan (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_raw[gi]),
        .level(btn_level[gi]),
        .tick (btn_tick[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw_raw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  assign sw_sync = sw_sync_reg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, REP_DELAY=10,
// REP_PERIOD=5; a second instance has auto-repeat disabled.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_raw, btn_raw2;
  logic [6:0] sw_raw, sw_raw2;
  logic [2:0] btn_level, btn_tick, btn_level2, btn_tick2;
  logic [6:0] sw_sync, sw_sync2;

  int checks = 0;
  int errors = 0;
  int tick_cnt;
  int base_err;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(3), .N_SW(7), .DB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(5)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_tick(btn_tick), .sw_sync(sw_sync)
  );

  btn_conditioner #(
    .N_BTN(3), .N_SW(7), .DB_CYCLES(4), .REP_DELAY(0), .REP_PERIOD(5)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn_raw(btn_raw2), .sw_raw(sw_raw2),
    .btn_level(btn_level2), .btn_tick(btn_tick2), .sw_sync(sw_sync2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    btn_raw  = '0;
    btn_raw2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic report(input string name);
    $display("scenario %s: %0d checks so far, %0d new errors", name, checks, errors - base_err);
    base_err = errors;
  endtask

  initial begin
    reset    = 1'b1;
    btn_raw  = '0;
    btn_raw2 = '0;
    sw_raw   = '0;
    sw_raw2  = '0;
    base_err = 0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_tick", 32'(btn_tick), 32'd0);
    check("rst_sw", 32'(sw_sync2), 32'd0);
    reset = 1'b0;
    report("reset");

    // Clean press held for 40 sampled cycles, then release
    for (int e = 0; e < 56; e++) begin
      @(negedge clk);
      btn_raw[0] = (e < 40);
      @(posedge clk); #1;
      check("press_tick", 32'(btn_tick[0]),
            32'(e == 6 || e == 16 || e == 21 || e == 26 || e == 31 || e == 36 || e == 41));
      check("press_level", 32'(btn_level[0]), 32'(e >= 6 && e <= 45));
      check("press_other", 32'(btn_tick[2:1]), 32'd0);
    end
    report("clean_press");

    do_reset();
    // Bounce: 3 high / 1 low five times, then stable high
    for (int e = 0; e < 32; e++) begin
      @(negedge clk);
      btn_raw[1] = (e < 20) ? ((e % 4) != 3) : 1'b1;
      @(posedge clk); #1;
      check("bounce_tick", 32'(btn_tick[1]), 32'(e == 26));
      check("bounce_level", 32'(btn_level[1]), 32'(e >= 26));
    end
    report("bounce");

    do_reset();
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      btn_raw[2] = (e < 3);
      @(posedge clk); #1;
      check("short_tick", 32'(btn_tick[2]), 32'd0);
      check("short_level", 32'(btn_level[2]), 32'd0);
    end
    report("short_pulse");

    do_reset();
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      btn_raw = 3'b111;
      @(posedge clk); #1;
      check("simul_tick", 32'(btn_tick), (e == 6) ? 32'h7 : 32'h0);
      check("simul_level", 32'(btn_level), (e >= 6) ? 32'h7 : 32'h0);
    end
    // Asynchronous reset between edges must clear a held level at once
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_level", 32'(btn_level), 32'd0);
    report("simultaneous");

    do_reset();
    // Reset active at edges 4 and 5 while the button stays high
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      btn_raw[0] = 1'b1;
      if (e == 4) begin
        reset = 1'b1;
        #1;
        check("midrst_now", 32'({btn_level[0], btn_tick[0]}), 32'd0);
      end
      if (e == 6) reset = 1'b0;
      @(posedge clk); #1;
      check("midrst_tick", 32'(btn_tick[0]), 32'(e == 12));
      check("midrst_level", 32'(btn_level[0]), 32'(e >= 12));
    end
    report("reset_mid_debounce");

    do_reset();
    tick_cnt = 0;
    for (int e = 0; e < 60; e++) begin
      @(negedge clk);
      sw_raw2     = 7'h55;
      btn_raw2[0] = (e < 50);
      @(posedge clk); #1;
      if (e == 0) check("sw_edge0", 32'(sw_sync2), 32'h0);
      if (e == 1) check("sw_edge1", 32'(sw_sync2), 32'h55);
      if (btn_tick2[0]) tick_cnt++;
      check("norep_tick", 32'(btn_tick2[0]), 32'(e == 6));
      check("norep_level", 32'(btn_level2[0]), 32'(e >= 6 && e <= 55));
    end
    check("norep_count", 32'(tick_cnt), 32'd1);
    report("switch_norepeat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
